vga_face_scheduler: RTL and testbench

Arbitrates face-change requests from several sources (audio classifier, switch panel, host) and drives the 2-bit `face_select` of the VGA face streaming source. Changes are applied only at frame boundaries, detected by monitoring the source's Avalon-ST output handshake, so a frame is never torn between two images. After each change the block holds the new face for a minimum number of frames. An optional slideshow mode is available.

---
 rtl/vga_face_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_vga_face_scheduler.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_face_scheduler.sv
// Frame-synchronous face selector for the VGA face streaming source: arbitrates
// requests, switches only at frame ends, then holds. Optional slideshow: VGA_FACE_AUTOCYCLE_EN.
module vga_face_scheduler #(
  parameter int NUM_REQ      = 3,
  parameter int NUM_FACES    = 3,
  parameter int HOLD_FRAMES  = 30,
  parameter int CYCLE_FRAMES = 120
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [2*NUM_REQ-1:0] req_face,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic                 st_valid,
  input  logic                 st_ready,
  input  logic                 st_endofpacket,
  output logic [1:0]           face_select,
  output logic                 switch_pulse,
  output logic                 busy
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [2:0] FACE_LIMIT = 3'(NUM_FACES);
  localparam logic [7:0] HOLD_LAST  = (HOLD_FRAMES == 0) ? 8'd0 : 8'(HOLD_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_OPEN    = 2'd0,
    ST_PENDING = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] face_q, face_d;
  logic [1:0] pending_q, pending_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       pulse_q, pulse_d;

  logic             eof_s;
  logic             any_req_s;
  logic [IDXW-1:0]  grant_idx_s;
  logic [NUM_REQ-1:0] grant_s;
  logic [1:0]       sel_face_s;
  logic             drop_s;

  assign eof_s = st_valid & st_ready & st_endofpacket;

  // Fixed-priority pick: lowest index wins, so scan downward and keep the last hit.
  always_comb begin
    any_req_s   = 1'b0;
    grant_idx_s = '0;
    grant_s     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        any_req_s   = 1'b1;
        grant_idx_s = IDXW'(i);
      end
    end
    if (any_req_s) begin
      grant_s[grant_idx_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
  end

  assign sel_face_s = req_face[2*grant_idx_s +: 2];
  assign drop_s     = ({1'b0, sel_face_s} >= FACE_LIMIT) || (sel_face_s == face_q);

  assign req_ready    = ((state_q == ST_OPEN) && !reset) ? grant_s : '0;
  assign busy         = (state_q != ST_OPEN);
  assign face_select  = face_q;
  assign switch_pulse = pulse_q;

`ifdef VGA_FACE_AUTOCYCLE_EN
  localparam logic [15:0] CYCLE_LAST = 16'(CYCLE_FRAMES - 1);
  logic [15:0] idle_cnt_q, idle_cnt_d;
`endif

  // Next-state and register-update decode for the OPEN/PENDING/HOLD controller.
  always_comb begin
    state_d    = state_q;
    face_d     = face_q;
    pending_d  = pending_q;
    hold_cnt_d = hold_cnt_q;
    pulse_d    = 1'b0;
`ifdef VGA_FACE_AUTOCYCLE_EN
    idle_cnt_d = idle_cnt_q;
`endif
    case (state_q)
      ST_OPEN: begin
        if (any_req_s) begin
`ifdef VGA_FACE_AUTOCYCLE_EN
          idle_cnt_d = 16'd0;
`endif
          if (drop_s) begin
            state_d = ST_OPEN;
          end else begin
            pending_d = sel_face_s;
            state_d   = ST_PENDING;
          end
        end else begin
`ifdef VGA_FACE_AUTOCYCLE_EN
          // Slideshow advance only counts genuinely idle frames.
          if (eof_s) begin
            if (idle_cnt_q == CYCLE_LAST) begin
              idle_cnt_d = 16'd0;
              face_d     = ({1'b0, face_q} + 3'd1 >= FACE_LIMIT) ? 2'd0 : face_q + 2'd1;
              pulse_d    = 1'b1;
              hold_cnt_d = 8'd0;
              state_d    = (HOLD_FRAMES == 0) ? ST_OPEN : ST_HOLD;
            end else begin
              idle_cnt_d = idle_cnt_q + 16'd1;
            end
          end else begin
            idle_cnt_d = idle_cnt_q;
          end
`else
          state_d = ST_OPEN;
`endif
        end
      end
      ST_PENDING: begin
        if (eof_s) begin
          face_d     = pending_q;
          pulse_d    = 1'b1;
          hold_cnt_d = 8'd0;
          state_d    = (HOLD_FRAMES == 0) ? ST_OPEN : ST_HOLD;
        end else begin
          state_d = ST_PENDING;
        end
      end
      ST_HOLD: begin
        if (eof_s) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
          state_d    = (hold_cnt_q == HOLD_LAST) ? ST_OPEN : ST_HOLD;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_OPEN;
      end
    endcase
`ifdef VGA_FACE_AUTOCYCLE_EN
    if (state_d != ST_OPEN) begin
      idle_cnt_d = 16'd0;
    end else begin
      idle_cnt_d = idle_cnt_d;
    end
`endif
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_OPEN;
      face_q     <= 2'd0;
      pending_q  <= 2'd0;
      hold_cnt_q <= 8'd0;
      pulse_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      face_q     <= face_d;
      pending_q  <= pending_d;
      hold_cnt_q <= hold_cnt_d;
      pulse_q    <= pulse_d;
    end
  end

`ifdef VGA_FACE_AUTOCYCLE_EN
  // Idle-frame counter for the slideshow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt_q <= 16'd0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_vga_face_scheduler.sv
// Directed bench for vga_face_scheduler (HOLD_FRAMES = 2); slideshow scenario
// runs on a second instance when VGA_FACE_AUTOCYCLE_EN is defined.
module tb_vga_face_scheduler;

  logic       clk;
  logic       reset;
  logic [2:0] req_valid;
  logic [5:0] req_face;
  logic [2:0] req_ready;
  logic       st_valid, st_ready, st_endofpacket;
  logic [1:0] face_select;
  logic       switch_pulse;
  logic       busy;

  int checks = 0;
  int errors = 0;

  vga_face_scheduler #(
    .NUM_REQ(3), .NUM_FACES(3), .HOLD_FRAMES(2), .CYCLE_FRAMES(1000)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_face(req_face),
    .req_ready(req_ready), .st_valid(st_valid), .st_ready(st_ready),
    .st_endofpacket(st_endofpacket), .face_select(face_select),
    .switch_pulse(switch_pulse), .busy(busy)
  );

`ifdef VGA_FACE_AUTOCYCLE_EN
  logic [2:0] ac_ready;
  logic [1:0] ac_face;
  logic       ac_pulse;
  logic       ac_busy;

  vga_face_scheduler #(
    .NUM_REQ(3), .NUM_FACES(3), .HOLD_FRAMES(0), .CYCLE_FRAMES(4)
  ) dut_ac (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_face(req_face),
    .req_ready(ac_ready), .st_valid(st_valid), .st_ready(st_ready),
    .st_endofpacket(st_endofpacket), .face_select(ac_face),
    .switch_pulse(ac_pulse), .busy(ac_busy)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_eof();
    st_valid = 1'b1; st_ready = 1'b1; st_endofpacket = 1'b1;
    tick();
    st_valid = 1'b0; st_ready = 1'b0; st_endofpacket = 1'b0;
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    tick();
    #2 reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 3'b001; req_face = 6'b00_00_10;
    #3;
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready got %b want 000", req_ready); end
    checks++; if (face_select !== 2'd0) begin errors++; $display("FAIL reset_face got %0d want 0", face_select); end
    checks++; if (switch_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got %b want 0", switch_pulse); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    req_valid = 3'b000;
    tick();
    #2 reset = 1'b0;
    tick();
  endtask

  task automatic test_basic_switch();
    do_reset();
    repeat (3) tick();
    req_valid = 3'b001; req_face = 6'b00_00_10;
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL basic_accept got %b want 001", req_ready); end
    tick();
    req_valid = 3'b000;
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL basic_ready_once got %b want 000", req_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", busy); end
    repeat (5) tick();
    checks++; if (face_select !== 2'd0) begin errors++; $display("FAIL basic_wait_face got %0d want 0", face_select); end
    do_eof();
    checks++; if (face_select !== 2'd2) begin errors++; $display("FAIL basic_face got %0d want 2", face_select); end
    checks++; if (switch_pulse !== 1'b1) begin errors++; $display("FAIL basic_pulse got %b want 1", switch_pulse); end
    tick();
    checks++; if (switch_pulse !== 1'b0) begin errors++; $display("FAIL basic_pulse_once got %b want 0", switch_pulse); end
  endtask

  task automatic test_priority_hold();
    do_reset();
    req_valid = 3'b101; req_face = 6'b10_00_01;
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL prio_winner got %b want 001", req_ready); end
    tick();
    req_valid = 3'b100;
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL prio_pending_ready got %b want 000", req_ready); end
    do_eof();
    checks++; if (face_select !== 2'd1) begin errors++; $display("FAIL prio_face1 got %0d want 1", face_select); end
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL prio_hold0_ready got %b want 000", req_ready); end
    do_eof();
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL prio_hold1_ready got %b want 000", req_ready); end
    do_eof();
    checks++; if (req_ready !== 3'b100) begin errors++; $display("FAIL prio_reopen_ready got %b want 100", req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL prio_reopen_busy got %b want 0", busy); end
    tick();
    req_valid = 3'b000;
    checks++; if (face_select !== 2'd1) begin errors++; $display("FAIL prio_face_before got %0d want 1", face_select); end
    do_eof();
    checks++; if (face_select !== 2'd2) begin errors++; $display("FAIL prio_face2 got %0d want 2", face_select); end
  endtask

  task automatic test_drop();
    do_reset();
    req_valid = 3'b010; req_face = 6'b00_00_00;
    #1;
    checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL drop_same_ready got %b want 010", req_ready); end
    tick();
    req_valid = 3'b000;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_same_busy got %b want 0", busy); end
    req_valid = 3'b001; req_face = 6'b00_00_11;
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL drop_bad_ready got %b want 001", req_ready); end
    tick();
    req_valid = 3'b000;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_bad_busy got %b want 0", busy); end
    do_eof();
    checks++; if (face_select !== 2'd0) begin errors++; $display("FAIL drop_face got %0d want 0", face_select); end
    checks++; if (switch_pulse !== 1'b0) begin errors++; $display("FAIL drop_pulse got %b want 0", switch_pulse); end
  endtask

  task automatic test_coincident_eof();
    do_reset();
    req_valid = 3'b001; req_face = 6'b00_00_01;
    do_eof();
    req_valid = 3'b000;
    checks++; if (face_select !== 2'd0) begin errors++; $display("FAIL coin_face got %0d want 0", face_select); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL coin_busy got %b want 1", busy); end
    do_eof();
    checks++; if (face_select !== 2'd1) begin errors++; $display("FAIL coin_next_face got %0d want 1", face_select); end
    checks++; if (switch_pulse !== 1'b1) begin errors++; $display("FAIL coin_pulse got %b want 1", switch_pulse); end
  endtask

  task automatic test_reset_mid_pending();
    do_reset();
    req_valid = 3'b001; req_face = 6'b00_00_01;
    tick();
    req_valid = 3'b000;
    do_eof(); do_eof(); do_eof();
    req_valid = 3'b001; req_face = 6'b00_00_10;
    tick();
    req_valid = 3'b000;
    checks++; if (face_select !== 2'd1) begin errors++; $display("FAIL rmp_pre_face got %0d want 1", face_select); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmp_pre_busy got %b want 1", busy); end
    #2 reset = 1'b1;
    #1;
    checks++; if (face_select !== 2'd0) begin errors++; $display("FAIL rmp_face got %0d want 0", face_select); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmp_busy got %b want 0", busy); end
    tick();
    #2 reset = 1'b0;
    tick();
    do_eof();
    checks++; if (face_select !== 2'd0) begin errors++; $display("FAIL rmp_after_face got %0d want 0", face_select); end
    checks++; if (switch_pulse !== 1'b0) begin errors++; $display("FAIL rmp_after_pulse got %b want 0", switch_pulse); end
  endtask

`ifdef VGA_FACE_AUTOCYCLE_EN
  task automatic test_autocycle();
    do_reset();
    do_eof(); do_eof(); do_eof();
    checks++; if (ac_face !== 2'd0) begin errors++; $display("FAIL ac_eof3 got %0d want 0", ac_face); end
    do_eof();
    checks++; if (ac_face !== 2'd1) begin errors++; $display("FAIL ac_eof4 got %0d want 1", ac_face); end
    checks++; if (ac_pulse !== 1'b1) begin errors++; $display("FAIL ac_pulse4 got %b want 1", ac_pulse); end
    do_eof(); do_eof(); do_eof();
    checks++; if (ac_face !== 2'd1) begin errors++; $display("FAIL ac_eof7 got %0d want 1", ac_face); end
    do_eof();
    checks++; if (ac_face !== 2'd2) begin errors++; $display("FAIL ac_eof8 got %0d want 2", ac_face); end
    do_reset();
    do_eof(); do_eof();
    req_valid = 3'b001; req_face = 6'b00_00_10;
    do_eof();
    req_valid = 3'b000;
    checks++; if (ac_face !== 2'd0) begin errors++; $display("FAIL ac_req_eof3 got %0d want 0", ac_face); end
    do_eof();
    checks++; if (ac_face !== 2'd2) begin errors++; $display("FAIL ac_req_eof4 got %0d want 2", ac_face); end
    do_eof(); do_eof(); do_eof();
    checks++; if (ac_face !== 2'd2) begin errors++; $display("FAIL ac_restart_eof7 got %0d want 2", ac_face); end
    do_eof();
    checks++; if (ac_face !== 2'd0) begin errors++; $display("FAIL ac_restart_eof8 got %0d want 0", ac_face); end
  endtask
`endif

  initial begin
    reset = 1'b1;
    req_valid = 3'b000; req_face = 6'b000000;
    st_valid = 1'b0; st_ready = 1'b0; st_endofpacket = 1'b0;
    test_reset();
    test_basic_switch();
    test_priority_hold();
    test_drop();
    test_coincident_eof();
    test_reset_mid_pending();
`ifdef VGA_FACE_AUTOCYCLE_EN
    test_autocycle();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
